// File: rtl/status_stack_if.sv
// Bus between the ALU/control unit and status_stack_unit; the unit is the slave.
// With STATUS_COND_EVAL_EN defined, the bus also carries cond_sel/cond_true.
interface status_stack_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4
);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  carry_in;
    logic                  overflow_in;
    logic                  status_wr;
    logic [3:0]            flag_mask;
    logic                  flags_load;
    logic [3:0]            flags_in;
    logic                  push;
    logic                  pop;
    logic                  err_clr;

    logic [3:0]            flags;
    logic                  flag_Z;
    logic                  flag_N;
    logic                  flag_C;
    logic                  flag_V;
    logic                  stack_full;
    logic                  stack_empty;
    logic [CW-1:0]         stack_count;
    logic                  err_ovf;
    logic                  err_unf;
`ifdef STATUS_COND_EVAL_EN
    logic [3:0]            cond_sel;
    logic                  cond_true;
`endif

    modport master (
        output alu_result, carry_in, overflow_in, status_wr, flag_mask,
               flags_load, flags_in, push, pop, err_clr,
`ifdef STATUS_COND_EVAL_EN
        output cond_sel,
        input  cond_true,
`endif
        input  flags, flag_Z, flag_N, flag_C, flag_V,
               stack_full, stack_empty, stack_count, err_ovf, err_unf
    );

    modport slave (
        input  alu_result, carry_in, overflow_in, status_wr, flag_mask,
               flags_load, flags_in, push, pop, err_clr,
`ifdef STATUS_COND_EVAL_EN
        input  cond_sel,
        output cond_true,
`endif
        output flags, flag_Z, flag_N, flag_C, flag_V,
               stack_full, stack_empty, stack_count, err_ovf, err_unf
    );
endinterface

// File: rtl/status_stack_unit.sv
// {V,C,N,Z} status register with masked ALU update, direct load and a bounded save/restore stack.
// Optional condition evaluator enabled by defining STATUS_COND_EVAL_EN.
module status_stack_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clock,
    input  logic          status_reset,
    status_stack_if.slave bus
);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [3:0]    flags_reg, flags_next;
    logic [CW-1:0] count_reg, count_next;
    logic          err_ovf_reg, err_ovf_next;
    logic          err_unf_reg, err_unf_next;

    logic [3:0]    stack_mem [STACK_DEPTH];

    logic [3:0]    derived;
    logic [3:0]    wr_merge;
    logic          full, empty;
    logic          push_only, pop_only;
    logic          push_ok, pop_ok;
    logic          ovf_evt, unf_evt;
    logic [IW-1:0] wr_idx, top_idx;

    assign derived = {bus.overflow_in, bus.carry_in,
                      bus.alu_result[DATA_WIDTH-1], (bus.alu_result == '0)};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign wr_merge[gi] = bus.flag_mask[gi] ? derived[gi] : flags_reg[gi];
        end
    endgenerate

    assign full  = (count_reg == CW'(STACK_DEPTH));
    assign empty = (count_reg == '0);

    // A simultaneous push and pop cancel each other without raising any error.
    assign push_only = bus.push & ~bus.pop;
    assign pop_only  = bus.pop & ~bus.push;
    assign push_ok   = push_only & ~full;
    assign pop_ok    = pop_only & ~empty;
    assign ovf_evt   = push_only & full;
    assign unf_evt   = pop_only & empty;

    assign wr_idx  = count_reg[IW-1:0];
    assign top_idx = IW'(count_reg - CW'(1));

    always_comb begin
        flags_next   = flags_reg;
        count_next   = count_reg;
        err_ovf_next = ovf_evt | (err_ovf_reg & ~bus.err_clr);
        err_unf_next = unf_evt | (err_unf_reg & ~bus.err_clr);

        if (pop_ok)
            flags_next = stack_mem[top_idx];
        else if (bus.flags_load)
            flags_next = bus.flags_in;
        else if (bus.status_wr)
            flags_next = wr_merge;

        if (push_ok)
            count_next = count_reg + CW'(1);
        else if (pop_ok)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clock or posedge status_reset) begin
        if (status_reset) begin
            flags_reg   <= '0;
            count_reg   <= '0;
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
        end else begin
            flags_reg   <= flags_next;
            count_reg   <= count_next;
            err_ovf_reg <= err_ovf_next;
            err_unf_reg <= err_unf_next;
        end
    end

    // Stack storage holds no reset; the count alone defines which entries are live.
    // The pushed value is the registered flags, i.e. the pre-update value.
    always_ff @(posedge clock) begin
        if (push_ok && !status_reset)
            stack_mem[wr_idx] <= flags_reg;
    end

    assign bus.flags       = flags_reg;
    assign bus.flag_Z      = flags_reg[0];
    assign bus.flag_N      = flags_reg[1];
    assign bus.flag_C      = flags_reg[2];
    assign bus.flag_V      = flags_reg[3];
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_count = count_reg;
    assign bus.err_ovf     = err_ovf_reg;
    assign bus.err_unf     = err_unf_reg;

`ifdef STATUS_COND_EVAL_EN
    logic cond_next;

    always_comb begin
        cond_next = 1'b0;
        case (bus.cond_sel)
            4'd0:    cond_next = 1'b1;
            4'd1:    cond_next = flags_reg[0];
            4'd2:    cond_next = ~flags_reg[0];
            4'd3:    cond_next = flags_reg[1];
            4'd4:    cond_next = ~flags_reg[1];
            4'd5:    cond_next = flags_reg[2];
            4'd6:    cond_next = ~flags_reg[2];
            4'd7:    cond_next = flags_reg[3];
            4'd8:    cond_next = ~flags_reg[3];
            4'd9:    cond_next = flags_reg[1] ^ flags_reg[3];
            4'd10:   cond_next = ~(flags_reg[1] ^ flags_reg[3]);
            4'd11:   cond_next = flags_reg[2] & ~flags_reg[0];
            default: cond_next = 1'b0;
        endcase
    end

    assign bus.cond_true = cond_next;
`else
    // Condition evaluator not built.
`endif
endmodule

// File: tb/tb_status_stack_unit.sv
// Directed self-checking bench for status_stack_unit (DATA_WIDTH=16, STACK_DEPTH=4).
module tb_status_stack_unit;
    logic clock;
    logic status_reset;
    int   checks;
    int   failures;
    int   cycle_no;

    status_stack_if #(.DATA_WIDTH(16), .STACK_DEPTH(4)) bus ();

    status_stack_unit #(.DATA_WIDTH(16), .STACK_DEPTH(4)) dut (
        .clock       (clock),
        .status_reset(status_reset),
        .bus         (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_ctrl();
        bus.alu_result  = 16'h0000;
        bus.carry_in    = 1'b0;
        bus.overflow_in = 1'b0;
        bus.status_wr   = 1'b0;
        bus.flag_mask   = 4'b0000;
        bus.flags_load  = 1'b0;
        bus.flags_in    = 4'b0000;
        bus.push        = 1'b0;
        bus.pop         = 1'b0;
        bus.err_clr     = 1'b0;
`ifdef STATUS_COND_EVAL_EN
        bus.cond_sel    = 4'd0;
`endif
    endtask

    // One clock edge; outputs are sampled 1 ns after it, then controls drop.
    task automatic step();
        @(posedge clock);
        #1;
        cycle_no++;
        $display("cycle %0d: flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
                 cycle_no, bus.flags, bus.stack_count, bus.stack_full,
                 bus.stack_empty, bus.err_ovf, bus.err_unf);
        clear_ctrl();
    endtask

    task automatic load_flags(input logic [3:0] v);
        bus.flags_load = 1'b1;
        bus.flags_in   = v;
        step();
    endtask

    task automatic test_reset();
        status_reset = 1'b1;
        clear_ctrl();
        #12;
        checks++;
        if (bus.flags !== 4'b0000 || bus.stack_count !== 3'd0 || bus.stack_empty !== 1'b1 ||
            bus.stack_full !== 1'b0 || bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: flags=%b count=%0d empty=%b full=%b ovf=%b unf=%b required 0000/0/1/0/0/0",
                     bus.flags, bus.stack_count, bus.stack_empty, bus.stack_full, bus.err_ovf, bus.err_unf);
        end
        status_reset = 1'b0;
        // Build some state: an underflow error, flags 1010 and two stack entries.
        bus.pop = 1'b1;
        step();
        load_flags(4'b1010);
        bus.push = 1'b1;
        step();
        bus.push = 1'b1;
        step();
        checks++;
        if (bus.stack_count !== 3'd2 || bus.flags !== 4'b1010 || bus.err_unf !== 1'b1) begin
            failures++;
            $display("FAIL reset_prep: count=%0d flags=%b unf=%b required 2/1010/1",
                     bus.stack_count, bus.flags, bus.err_unf);
        end
        // Assert reset mid-cycle and check without any clock edge.
        #2;
        status_reset = 1'b1;
        #1;
        checks++;
        if (bus.flags !== 4'b0000 || bus.stack_count !== 3'd0 || bus.stack_empty !== 1'b1 ||
            bus.stack_full !== 1'b0 || bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: flags=%b count=%0d empty=%b full=%b ovf=%b unf=%b required 0000/0/1/0/0/0",
                     bus.flags, bus.stack_count, bus.stack_empty, bus.stack_full, bus.err_ovf, bus.err_unf);
        end
        @(posedge clock);
        #3;
        status_reset = 1'b0;
        step();
        checks++;
        if (bus.stack_count !== 3'd0 || bus.flags !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release: count=%0d flags=%b required 0/0000", bus.stack_count, bus.flags);
        end
    endtask

    task automatic test_flag_update();
        bus.status_wr   = 1'b1;
        bus.flag_mask   = 4'b1111;
        bus.alu_result  = 16'h8000;
        bus.carry_in    = 1'b1;
        bus.overflow_in = 1'b1;
        step();
        checks++;
        if (bus.flags !== 4'b1110 || bus.flag_V !== 1'b1 || bus.flag_C !== 1'b1 ||
            bus.flag_N !== 1'b1 || bus.flag_Z !== 1'b0) begin
            failures++;
            $display("FAIL flag_full_mask: flags=%b VCNZ=%b%b%b%b required 1110",
                     bus.flags, bus.flag_V, bus.flag_C, bus.flag_N, bus.flag_Z);
        end
        bus.status_wr  = 1'b1;
        bus.flag_mask  = 4'b0001;
        bus.alu_result = 16'h0000;
        step();
        checks++;
        if (bus.flags !== 4'b1111) begin
            failures++;
            $display("FAIL flag_z_mask: flags=%b required 1111", bus.flags);
        end
        // Legacy Z/N mask: C and V hold even though the inputs would clear them.
        bus.status_wr  = 1'b1;
        bus.flag_mask  = 4'b0011;
        bus.alu_result = 16'h0001;
        step();
        checks++;
        if (bus.flags !== 4'b1100) begin
            failures++;
            $display("FAIL flag_legacy_mask: flags=%b required 1100", bus.flags);
        end
        // flags_load outranks status_wr.
        bus.status_wr  = 1'b1;
        bus.flag_mask  = 4'b1111;
        bus.flags_load = 1'b1;
        bus.flags_in   = 4'b0110;
        step();
        checks++;
        if (bus.flags !== 4'b0110) begin
            failures++;
            $display("FAIL load_priority: flags=%b required 0110", bus.flags);
        end
    endtask

    task automatic test_push_pop();
        load_flags(4'b0101);
        bus.push = 1'b1;
        step();
        checks++;
        if (bus.stack_count !== 3'd1 || bus.stack_empty !== 1'b0) begin
            failures++;
            $display("FAIL push_count: count=%0d empty=%b required 1/0", bus.stack_count, bus.stack_empty);
        end
        bus.status_wr  = 1'b1;
        bus.flag_mask  = 4'b1111;
        bus.alu_result = 16'h8000;
        step();
        checks++;
        if (bus.flags !== 4'b0010) begin
            failures++;
            $display("FAIL push_pop_mid: flags=%b required 0010", bus.flags);
        end
        bus.pop = 1'b1;
        step();
        checks++;
        if (bus.flags !== 4'b0101 || bus.stack_count !== 3'd0 || bus.stack_empty !== 1'b1) begin
            failures++;
            $display("FAIL pop_restore: flags=%b count=%0d empty=%b required 0101/0/1",
                     bus.flags, bus.stack_count, bus.stack_empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            load_flags(4'(i));
            bus.push = 1'b1;
            step();
        end
        checks++;
        if (bus.stack_full !== 1'b1 || bus.err_ovf !== 1'b1 || bus.stack_count !== 3'd4) begin
            failures++;
            $display("FAIL overflow: full=%b ovf=%b count=%0d required 1/1/4",
                     bus.stack_full, bus.err_ovf, bus.stack_count);
        end
        for (int i = 4; i >= 1; i--) begin
            bus.pop = 1'b1;
            step();
            checks++;
            if (bus.flags !== 4'(i) || bus.stack_count !== 3'(i - 1)) begin
                failures++;
                $display("FAIL overflow_pop%0d: flags=%b count=%0d required %b/%0d",
                         i, bus.flags, bus.stack_count, 4'(i), i - 1);
            end
        end
        bus.err_clr = 1'b1;
        step();
        checks++;
        if (bus.err_ovf !== 1'b0 || bus.stack_empty !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b empty=%b required 0/1", bus.err_ovf, bus.stack_empty);
        end
    endtask

    task automatic test_underflow();
        load_flags(4'b1000);
        bus.pop        = 1'b1;
        bus.status_wr  = 1'b1;
        bus.flag_mask  = 4'b1111;
        bus.alu_result = 16'h0000;
        step();
        checks++;
        if (bus.err_unf !== 1'b1 || bus.flags !== 4'b0001 || bus.stack_count !== 3'd0) begin
            failures++;
            $display("FAIL underflow: unf=%b flags=%b count=%0d required 1/0001/0",
                     bus.err_unf, bus.flags, bus.stack_count);
        end
        bus.err_clr = 1'b1;
        step();
        checks++;
        if (bus.err_unf !== 1'b0) begin
            failures++;
            $display("FAIL unf_clear: unf=%b required 0", bus.err_unf);
        end
        // Error set in the same cycle as err_clr wins.
        bus.err_clr = 1'b1;
        bus.pop     = 1'b1;
        step();
        checks++;
        if (bus.err_unf !== 1'b1 || bus.err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL unf_set_wins: unf=%b ovf=%b required 1/0", bus.err_unf, bus.err_ovf);
        end
        bus.err_clr = 1'b1;
        step();
    endtask

    task automatic test_simultaneous();
        load_flags(4'b0011);
        bus.push = 1'b1;
        step();
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        step();
        checks++;
        if (bus.stack_count !== 3'd1 || bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0 ||
            bus.flags !== 4'b0011) begin
            failures++;
            $display("FAIL push_and_pop: count=%0d ovf=%b unf=%b flags=%b required 1/0/0/0011",
                     bus.stack_count, bus.err_ovf, bus.err_unf, bus.flags);
        end
        load_flags(4'b0001);
        bus.push       = 1'b1;
        bus.status_wr  = 1'b1;
        bus.flag_mask  = 4'b1111;
        bus.alu_result = 16'h0042;
        bus.carry_in   = 1'b1;
        step();
        checks++;
        if (bus.flags !== 4'b0100 || bus.stack_count !== 3'd2) begin
            failures++;
            $display("FAIL push_with_wr: flags=%b count=%0d required 0100/2", bus.flags, bus.stack_count);
        end
        bus.pop = 1'b1;
        step();
        checks++;
        if (bus.flags !== 4'b0001 || bus.stack_count !== 3'd1) begin
            failures++;
            $display("FAIL pushed_pre_value: flags=%b count=%0d required 0001/1", bus.flags, bus.stack_count);
        end
        bus.pop        = 1'b1;
        bus.flags_load = 1'b1;
        bus.flags_in   = 4'b1111;
        step();
        checks++;
        if (bus.flags !== 4'b0011 || bus.stack_empty !== 1'b1) begin
            failures++;
            $display("FAIL pop_over_load: flags=%b empty=%b required 0011/1", bus.flags, bus.stack_empty);
        end
    endtask

    task automatic test_back_to_back();
        // Load and push in one cycle: the old value 0011 is saved, 1001 becomes current.
        bus.flags_load = 1'b1;
        bus.flags_in   = 4'b1001;
        bus.push       = 1'b1;
        step();
        bus.push = 1'b1;
        step();
        bus.pop = 1'b1;
        step();
        checks++;
        if (bus.flags !== 4'b1001 || bus.stack_count !== 3'd1) begin
            failures++;
            $display("FAIL b2b_pop1: flags=%b count=%0d required 1001/1", bus.flags, bus.stack_count);
        end
        bus.pop = 1'b1;
        step();
        checks++;
        if (bus.flags !== 4'b0011 || bus.stack_count !== 3'd0) begin
            failures++;
            $display("FAIL b2b_pop2: flags=%b count=%0d required 0011/0", bus.flags, bus.stack_count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cycle_no = 0;
        test_reset();
        test_flag_update();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
